// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into 32-bit words
// and writes them sequentially until a terminator word or a full memory ends the session.
module imem_loader #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              halt_seen,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam logic [31:0] TERM_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;

  // Session FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      byte_idx   <= 2'd0;
      word_buf   <= 24'd0;
      in_ready   <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      halt_seen  <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= COLLECT;
            byte_idx   <= 2'd0;
            wr_addr    <= '0;
            word_count <= '0;
            halt_seen  <= 1'b0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b1;
            in_ready   <= 1'b1;
          end
        end

        COLLECT: begin
          if (in_valid && in_ready) begin
            byte_idx <= byte_idx + 2'd1;
            // The fourth byte completes the word straight into the write register.
            case (byte_idx)
              2'd0: word_buf[23:16] <= in_byte;
              2'd1: word_buf[15:8]  <= in_byte;
              2'd2: word_buf[7:0]   <= in_byte;
              default: begin
                wr_data  <= {word_buf, in_byte};
                wr_en    <= 1'b1;
                in_ready <= 1'b0;
                state    <= WRITE;
              end
            endcase
          end
        end

        WRITE: begin
          wr_en      <= 1'b0;
          word_count <= word_count + CNT_W'(1);
          // Terminator check wins over the full-memory check.
          if (wr_data == TERM_WORD) begin
            state     <= DONE;
            halt_seen <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
          end else if (wr_addr == ADDR_W'(DEPTH - 1)) begin
            state    <= DONE;
            overflow <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
          end else begin
            wr_addr  <= wr_addr + ADDR_W'(1);
            in_ready <= 1'b1;
            state    <= COLLECT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-depth instance and a DEPTH=4 instance share stimulus.
module tb_imem_loader;

  bit          clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_byte;

  logic        rdy_a, wen_a, busy_a, done_a, halt_a, ovf_a;
  logic [9:0]  addr_a;
  logic [31:0] data_a;
  logic [10:0] wc_a;

  logic        rdy_b, wen_b, busy_b, done_b, halt_b, ovf_b;
  logic [1:0]  addr_b;
  logic [31:0] data_b;
  logic [2:0]  wc_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_loader dut_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(rdy_a), .wr_en(wen_a), .wr_addr(addr_a), .wr_data(data_a), .busy(busy_a),
    .done(done_a), .halt_seen(halt_a), .overflow(ovf_a), .word_count(wc_a)
  );

  imem_loader #(.DEPTH(4), .ADDR_W(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(rdy_b), .wr_en(wen_b), .wr_addr(addr_b), .wr_data(data_b), .busy(busy_b),
    .done(done_b), .halt_seen(halt_b), .overflow(ovf_b), .word_count(wc_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Hold in_valid until the selected instance accepts the byte (bounded).
  task automatic send_byte(input bit sel4, input logic [7:0] b);
    logic hs;
    int   n;
    in_valid = 1'b1;
    in_byte  = b;
    n = 0;
    do begin
      hs = sel4 ? rdy_b : rdy_a;
      tick();
      n++;
    end while (!hs && n < 20);
    in_valid = 1'b0;
    chk("handshake", 64'(hs), 64'd1);
  endtask

  task automatic check_write(input bit sel4, input logic [31:0] w, input int a);
    chk("wr_en_hi",  64'(sel4 ? wen_b : wen_a), 64'd1);
    chk("wr_addr",   64'(sel4 ? 10'(addr_b) : addr_a), 64'(a));
    chk("wr_data",   64'(sel4 ? data_b : data_a), 64'(w));
    chk("rdy_write", 64'(sel4 ? rdy_b : rdy_a), 64'd0);
    tick();
    chk("wr_en_lo",  64'(sel4 ? wen_b : wen_a), 64'd0);
  endtask

  task automatic send_word(input bit sel4, input logic [31:0] w, input int a);
    send_byte(sel4, w[31:24]);
    send_byte(sel4, w[23:16]);
    send_byte(sel4, w[15:8]);
    send_byte(sel4, w[7:0]);
    check_write(sel4, w, a);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    tick();

    // Reset state
    do_reset();
    chk("rst_ready", 64'(rdy_a), 64'd0);
    chk("rst_busy",  64'(busy_a), 64'd0);
    chk("rst_done",  64'(done_a), 64'd0);
    chk("rst_wc",    64'(wc_a), 64'd0);
    chk("rst_wen_b", 64'(wen_b), 64'd0);

    // Basic load with terminator
    pulse_start();
    chk("start_busy",  64'(busy_a), 64'd1);
    chk("start_ready", 64'(rdy_a), 64'd1);
    send_word(1'b0, 32'h0001_1020, 0);
    send_word(1'b0, 32'h0061_1020, 1);
    send_word(1'b0, 32'hFFFF_FFFF, 2);
    chk("basic_done", 64'(done_a), 64'd1);
    chk("basic_halt", 64'(halt_a), 64'd1);
    chk("basic_ovf",  64'(ovf_a), 64'd0);
    chk("basic_wc",   64'(wc_a), 64'd3);
    chk("basic_busy", 64'(busy_a), 64'd0);
    chk("basic_rdy",  64'(rdy_a), 64'd0);
    chk("basic_hold_data", 64'(data_a), 64'hFFFF_FFFF);

    // Stall mid-word
    do_reset();
    pulse_start();
    send_byte(1'b0, 8'h12);
    send_byte(1'b0, 8'h34);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_wen", 64'(wen_a), 64'd0);
      chk("stall_rdy", 64'(rdy_a), 64'd1);
    end
    send_byte(1'b0, 8'h56);
    chk("stall_wen3", 64'(wen_a), 64'd0);
    send_byte(1'b0, 8'h78);
    check_write(1'b0, 32'h1234_5678, 0);

    // Overflow on the DEPTH=4 instance
    do_reset();
    pulse_start();
    send_word(1'b1, 32'h1111_1111, 0);
    send_word(1'b1, 32'h2222_2222, 1);
    send_word(1'b1, 32'h3333_3333, 2);
    send_word(1'b1, 32'h4444_4444, 3);
    chk("ovf_done", 64'(done_b), 64'd1);
    chk("ovf_ovf",  64'(ovf_b), 64'd1);
    chk("ovf_halt", 64'(halt_b), 64'd0);
    chk("ovf_wc",   64'(wc_b), 64'd4);
    chk("ovf_addr", 64'(addr_b), 64'd3);
    chk("ovf_a_busy", 64'(busy_a), 64'd1);

    // Terminator exactly in the last slot
    do_reset();
    pulse_start();
    send_word(1'b1, 32'hAAAA_0001, 0);
    send_word(1'b1, 32'hAAAA_0002, 1);
    send_word(1'b1, 32'hAAAA_0003, 2);
    send_word(1'b1, 32'hFFFF_FFFF, 3);
    chk("last_halt", 64'(halt_b), 64'd1);
    chk("last_ovf",  64'(ovf_b), 64'd0);
    chk("last_wc",   64'(wc_b), 64'd4);
    chk("last_done", 64'(done_b), 64'd1);

    // Reset after two bytes discards the partial word
    do_reset();
    pulse_start();
    send_byte(1'b0, 8'hC0);
    send_byte(1'b0, 8'hDE);
    do_reset();
    chk("mid_wen",  64'(wen_a), 64'd0);
    chk("mid_rdy",  64'(rdy_a), 64'd0);
    chk("mid_busy", 64'(busy_a), 64'd0);
    chk("mid_addr", 64'(addr_a), 64'd0);
    chk("mid_data", 64'(data_a), 64'd0);
    chk("mid_wc",   64'(wc_a), 64'd0);
    pulse_start();
    send_word(1'b0, 32'hA5A5_5A5A, 0);

    // Reset coinciding with the fourth byte suppresses the write
    send_byte(1'b0, 8'h01);
    send_byte(1'b0, 8'h02);
    send_byte(1'b0, 8'h03);
    in_valid = 1'b1;
    in_byte  = 8'h04;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("rst4_wen",  64'(wen_a), 64'd0);
    chk("rst4_data", 64'(data_a), 64'd0);
    tick();
    chk("rst4_wen2", 64'(wen_a), 64'd0);

    // Start ignored mid-session, honoured in DONE
    pulse_start();
    send_byte(1'b0, 8'hDE);
    pulse_start();
    chk("ign_busy", 64'(busy_a), 64'd1);
    send_byte(1'b0, 8'hAD);
    send_byte(1'b0, 8'hBE);
    send_byte(1'b0, 8'hEF);
    check_write(1'b0, 32'hDEAD_BEEF, 0);
    send_word(1'b0, 32'hFFFF_FFFF, 1);
    chk("rs_done1", 64'(done_a), 64'd1);
    chk("rs_wc1",   64'(wc_a), 64'd2);
    pulse_start();
    chk("rs_done0", 64'(done_a), 64'd0);
    chk("rs_halt0", 64'(halt_a), 64'd0);
    chk("rs_wc0",   64'(wc_a), 64'd0);
    chk("rs_busy",  64'(busy_a), 64'd1);
    send_word(1'b0, 32'h0BAD_F00D, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
